// File: rtl/cpumc_arb.sv
// cpumc_arb: NUM_MASTERS-way arbiter for the shared cpumc bus with registered one-hot grants,
// a turnaround idle gap on every ownership change and a CPU stall. Round-robin option: CPUMC_ARB_ROUND_ROBIN_EN.
module cpumc_arb #(
    parameter int NUM_MASTERS = 3,
    parameter int AW          = 16,
    parameter int DW          = 8,
    parameter int TURN_CYCLES = 1
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [NUM_MASTERS-1:0]    req_in,
    input  logic [NUM_MASTERS*AW-1:0] m_a_in,
    input  logic [NUM_MASTERS-1:0]    m_r_nw_in,
    input  logic [NUM_MASTERS*DW-1:0] m_d_in,
    output logic [NUM_MASTERS-1:0]    gnt_out,
    output logic                      cpu_ready_out,
    output logic [2:0]                owner_out,
    output logic [AW-1:0]             cpumc_a_out,
    output logic                      cpumc_r_nw_out,
    output logic [DW-1:0]             cpumc_d_out
);

    // state   | meaning
    // ST_OWN  | owner_q holds the bus, gnt one-hot
    // ST_TURN | no owner, bus parked (a=0, r_nw=1, d=0), turnaround counter running

    typedef enum logic [0:0] {
        ST_OWN  = 1'b0,
        ST_TURN = 1'b1
    } state_t;

    localparam logic [2:0] TURN_LOAD = (TURN_CYCLES > 0) ? 3'(TURN_CYCLES - 1) : 3'd0;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
    logic [2:0]             owner_q, owner_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [2:0]             win;

    // CPU request is implicit, so its req bit carries no information.
    logic unused_req0;
    assign unused_req0 = req_in[0];

`ifdef CPUMC_ARB_ROUND_ROBIN_EN
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] rr_win;
    logic       rr_found;
    logic [3:0] rr_cand;
    logic       owner_holds;

    always_comb begin
        rr_win   = 3'd0;
        rr_found = 1'b0;
        rr_cand  = 4'd0;
        for (int k = 0; k < NUM_MASTERS - 1; k++) begin
            rr_cand = {1'b0, ptr_q} + 4'd1 + 4'(k);
            if (rr_cand > 4'(NUM_MASTERS - 1)) begin
                rr_cand = rr_cand - 4'(NUM_MASTERS - 1);
            end
            for (int i = 1; i < NUM_MASTERS; i++) begin
                if (!rr_found && rr_cand == 4'(i) && req_in[i]) begin
                    rr_found = 1'b1;
                    rr_win   = 3'(i);
                end
            end
        end
    end

    // A DMA/debug owner keeps the bus until it drops its own request.
    assign owner_holds = |(gnt_q[NUM_MASTERS-1:1] & req_in[NUM_MASTERS-1:1]);

    always_comb begin
        win = 3'd0;
        if (state_q == ST_OWN && owner_holds) begin
            win = owner_q;
        end else if (rr_found) begin
            win = rr_win;
        end
    end
`else
    always_comb begin
        win = 3'd0;
        for (int i = 1; i < NUM_MASTERS; i++) begin
            if (req_in[i]) begin
                win = 3'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
`ifdef CPUMC_ARB_ROUND_ROBIN_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            ST_OWN: begin
                if (win != owner_q) begin
                    if (TURN_CYCLES == 0) begin
                        for (int i = 0; i < NUM_MASTERS; i++) begin
                            gnt_d[i] = (win == 3'(i));
                        end
                        owner_d = win;
`ifdef CPUMC_ARB_ROUND_ROBIN_EN
                        if (win != 3'd0) ptr_d = win;
`endif
                    end else begin
                        state_d = ST_TURN;
                        cnt_d   = TURN_LOAD;
                        gnt_d   = '0;
                    end
                end
            end
            ST_TURN: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    // Winner is re-sampled here so a request dropped mid-turnaround is never granted.
                    state_d = ST_OWN;
                    for (int i = 0; i < NUM_MASTERS; i++) begin
                        gnt_d[i] = (win == 3'(i));
                    end
                    owner_d = win;
`ifdef CPUMC_ARB_ROUND_ROBIN_EN
                    if (win != 3'd0) ptr_d = win;
`endif
                end
            end
            default: begin
                state_d = ST_OWN;
                gnt_d   = {{(NUM_MASTERS-1){1'b0}}, 1'b1};
                owner_d = 3'd0;
                cnt_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_OWN;
            gnt_q   <= {{(NUM_MASTERS-1){1'b0}}, 1'b1};
            owner_q <= 3'd0;
            cnt_q   <= 3'd0;
`ifdef CPUMC_ARB_ROUND_ROBIN_EN
            ptr_q   <= 3'(NUM_MASTERS - 1);
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
`ifdef CPUMC_ARB_ROUND_ROBIN_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    logic [AW-1:0] bus_a;
    logic [DW-1:0] bus_d;
    logic          bus_r_nw;

    // AND-OR mux on the one-hot grant; an all-zero grant parks the bus as a read of 0.
    always_comb begin
        bus_a    = '0;
        bus_d    = '0;
        bus_r_nw = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            bus_a    = bus_a | (m_a_in[i*AW +: AW] & {AW{gnt_q[i]}});
            bus_d    = bus_d | (m_d_in[i*DW +: DW] & {DW{gnt_q[i]}});
            bus_r_nw = bus_r_nw | (m_r_nw_in[i] & gnt_q[i]);
        end
    end

    assign gnt_out        = gnt_q;
    assign owner_out      = owner_q;
    assign cpu_ready_out  = gnt_q[0];
    assign cpumc_a_out    = bus_a;
    assign cpumc_d_out    = bus_d;
    assign cpumc_r_nw_out = (gnt_q == '0) ? 1'b1 : bus_r_nw;

endmodule

// File: doc/cpumc_arb.md
Name: cpumc_arb

Overview:
- Parametrised arbiter for the CPU memory bus.
- Generalises the fixed three-way mux (debug > DMA > CPU) to NUM_MASTERS masters.
- Adds registered grants, a bus-turnaround gap with a safe idle cycle, and a per-master stall signal.
- Sits between all bus masters (CPU, sprite DMA, host debug, future APU DMC DMA) and the shared cpumc address/data/r_nw bus that feeds cart, wram, ppu and jp decode.

Parameters:
- NUM_MASTERS, 3: number of bus masters. Index 0 is the CPU/default owner; higher index means higher priority. Legal range 2..8.
- AW, 16: address width.
- DW, 8: data width.
- TURN_CYCLES, 1: idle cycles inserted on every ownership change. Legal range 0..7.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- req_in  input  NUM_MASTERS  per-master bus request, level; bit 0 ignored (CPU always wants the bus)
- m_a_in  input  NUM_MASTERS*AW  packed master addresses, master i at [i*AW +: AW]
- m_r_nw_in  input  NUM_MASTERS  per-master R/!W
- m_d_in  input  NUM_MASTERS*DW  packed master write data
- gnt_out  output  NUM_MASTERS  one-hot registered grant
- cpu_ready_out  output  1  CPU ready; high only when master 0 owns the bus
- owner_out  output  3  index of current owner, valid when gnt_out != 0
- cpumc_a_out  output  AW  muxed bus address
- cpumc_r_nw_out  output  1  muxed R/!W
- cpumc_d_out  output  DW  muxed write data

Behaviour:
- Reset (rst_in sampled high on a clk_in edge):
  - gnt_out = 1 (master 0), owner_out = 0, cpu_ready_out = 1.
  - Turn counter = 0, state = OWN.
  - Reset mid-transfer or mid-turnaround aborts immediately; no pending state survives.
- States: OWN (a master holds the bus) and TURN (no owner).
- Winner: the highest-index master i >= 1 with req_in[i] = 1. If none requests, the winner is 0.
- OWN transitions:
  - Winner == owner: stay in OWN.
  - Winner != owner and TURN_CYCLES > 0: go to TURN. Load counter = TURN_CYCLES-1, gnt_out = 0, cpu_ready_out = 0.
  - Winner != owner and TURN_CYCLES = 0: switch gnt_out directly to the winner in the same edge.
- TURN transitions:
  - Counter != 0: decrement and stay in TURN.
  - Counter == 0: re-evaluate the winner at that edge, grant it, go to OWN.
  - The winner is re-sampled there, so a request that drops during TURN is never granted.
- Preemption:
  - A higher-index request preempts a lower-index owner at the next edge, including preemption of DMA by debug.
  - The preempted master sees its gnt bit fall.
  - That master must hold its request and internal state until regranted; the arbiter does not replay the lost cycle.
- A master with gnt_out[i] = 1 that drops req_in[i] loses the bus at the next edge.
  - Exception: master 0 is never released except by preemption.
- Datapath (combinational from the registered grant):
  - cpumc_a_out, cpumc_r_nw_out and cpumc_d_out select the owner's inputs.
  - During TURN: a = 0, r_nw = 1, d = 0, so no spurious write can occur.
- cpu_ready_out = gnt_out[0], registered. The CPU stalls in the same cycle the grant leaves it.
- Latency:
  - Request to grant = 1 + TURN_CYCLES edges.
  - Release to CPU ready = 1 + TURN_CYCLES edges.
- Simultaneous requests: higher index wins. Lower requesters wait; there is no starvation guard in the base build.
- owner_out holds its last value during TURN.

Optional Feature:
- Macro: CPUMC_ARB_ROUND_ROBIN_EN.
- When defined:
  - Masters 1..NUM_MASTERS-1 arbitrate round-robin.
  - A 3-bit last-served pointer records the most recently granted index >= 1.
  - The next winner is the first requester searching upward from pointer+1, wrapping from NUM_MASTERS-1 to 1.
  - The owner is not preempted by other requesters >= 1; only release ends its tenure. Master 0 is still preempted by any request.
  - The pointer resets to NUM_MASTERS-1, so master 1 is searched first.
- When undefined: fixed priority as described above, and the pointer logic is absent.

Test Plan:
- Reset, then idle 10 cycles -> gnt_out = 3'b001, cpu_ready_out = 1, cpumc_a_out tracks m_a_in of master 0 (drive 16'h8000 -> observe 16'h8000).
- TURN_CYCLES = 1, assert req_in[1] with m_a_in[1] = 16'h0200 and r_nw = 1 -> one TURN cycle (gnt_out = 0, r_nw = 1, a = 0), then gnt_out = 3'b010, a = 16'h0200, cpu_ready_out = 0; drop req -> TURN, then master 0 regranted.
- Master 1 owns and writes (r_nw = 0, d = 8'h5A), then req_in[2] rises -> gnt_out = 0 on the next edge, 3'b100 one edge later; r_nw is never 0 in the TURN cycle.
- req_in[1] and req_in[2] rise in the same cycle -> master 2 is granted first; master 1 is granted only after req_in[2] falls plus one TURN cycle.
- Assert rst_in during TURN while req_in[2] is held high -> next cycle gnt_out = 3'b001, cpu_ready_out = 1; master 2 is granted 1 + TURN_CYCLES edges after rst_in falls.
- CPUMC_ARB_ROUND_ROBIN_EN defined, NUM_MASTERS = 4, masters 1-3 requesting continuously, each releasing after 4 grant cycles -> grant order 1, 2, 3, 1; no preemption is observed.
